// File: rtl/cellrv32_package.sv
// Shared address map and types for the PWM fade engine and the PWM slave it drives.
package cellrv32_package;

  localparam logic [31:0] pwm_fader_base_c      = 32'hFFFFF700;
  localparam int          pwm_fader_size_c      = 16;
  localparam logic [31:0] pwm_fader_ctrl_addr_c = pwm_fader_base_c;
  localparam logic [31:0] pwm_fader_tgt0_addr_c = pwm_fader_base_c + 32'd4;
  localparam logic [31:0] pwm_fader_tgt1_addr_c = pwm_fader_base_c + 32'd8;
  localparam logic [31:0] pwm_fader_tgt2_addr_c = pwm_fader_base_c + 32'd12;

  localparam logic [31:0] pwm_dc0_addr_c = 32'hFFFFFF54;
  localparam logic [31:0] pwm_dc1_addr_c = 32'hFFFFFF58;
  localparam logic [31:0] pwm_dc2_addr_c = 32'hFFFFFF5C;

  typedef enum logic [1:0] {IDLE, STEP, ISSUE, WAIT} fader_state_t;

  function automatic logic [31:0] pwm_dc_addr(input logic [1:0] g);
    case (g)
      2'd0:    return pwm_dc0_addr_c;
      2'd1:    return pwm_dc1_addr_c;
      default: return pwm_dc2_addr_c;
    endcase
  endfunction

endpackage

// File: rtl/cellrv32_pwm_fader_step.sv
// One channel of the fade engine: moves cur toward tgt by at most step, never past tgt.
module cellrv32_pwm_fader_step (
  input  logic [7:0] cur,
  input  logic [7:0] tgt,
  input  logic [7:0] step,
  output logic [7:0] nxt,
  output logic       changed
);

  logic       up;
  logic [8:0] diff;

  always_comb begin
    up   = (tgt >= cur);
    diff = up ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt});
    // A remaining distance within one step lands exactly on the target, so cur cannot wrap.
    if (diff <= {1'b0, step}) begin
      nxt = tgt;
    end else if (up) begin
      nxt = cur + step;
    end else begin
      nxt = cur - step;
    end
    changed = (nxt != cur);
  end

endmodule

// File: rtl/cellrv32_pwm_fader.sv
// PWM fade engine: steps per-channel duty toward CPU targets and pushes changed DC words to the PWM.
module cellrv32_pwm_fader
  import cellrv32_package::*;
#(
  parameter int NUM_CHANNELS = 12,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        rden_i,
  input  logic        wren_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        clkgen_en_o,
  input  logic [7:0]  clkgen_i,
  output logic [31:0] pwm_addr_o,
  output logic        pwm_wren_o,
  output logic [31:0] pwm_data_o,
  input  logic        pwm_ack_i
);

  localparam int NCH = 12;

  logic           ctrl_en;
  logic [2:0]     ctrl_prsc;
  logic [7:0]     ctrl_step;
  logic           err;
  logic [7:0]     cur     [NCH];
  logic [7:0]     tgt     [NCH];
  logic [7:0]     cur_nxt [NCH];
  logic [NCH-1:0] ch_chg;
  logic [2:0]     grp_chg;
  logic [2:0]     dirty;
  logic           pending;
  logic [7:0]     tmo;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [31:0]    cur_grp [3];
  logic [31:0]    tgt_grp [3];
  fader_state_t   state, state_nxt;

  logic        hit, acc_wr, acc_rd, ctrl_wr, snap, disable_wr, tick, timeout, busy;
  logic [1:0]  sel, issue_g;
  logic [31:0] rdata;
  logic        unused_bits;

  function automatic logic [1:0] lowest_dirty(input logic [2:0] d);
    if (d[0]) return 2'd0;
    if (d[1]) return 2'd1;
    return 2'd2;
  endfunction

  assign hit         = (addr_i[31:4] == pwm_fader_base_c[31:4]);
  assign sel         = addr_i[3:2];
  assign acc_wr      = wren_i & hit;
  assign acc_rd      = rden_i & hit;
  assign ctrl_wr     = acc_wr & (sel == 2'd0);
  assign snap        = ctrl_wr & data_i[12] & data_i[0];
  assign disable_wr  = ctrl_wr & ~data_i[0];
  assign tick        = clkgen_i[ctrl_prsc] & ctrl_en;
  assign timeout     = (state == WAIT) && !pwm_ack_i && (tmo == 8'(ACK_TIMEOUT - 1));
  assign busy        = (state != IDLE) || (dirty != 3'd0);
  assign issue_g     = lowest_dirty(dirty);
  assign clkgen_en_o = ctrl_en;
  assign unused_bits = ^{addr_i[1:0], data_i[31:13]};

  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_step
      cellrv32_pwm_fader_step u_step (
        .cur     (cur[i]),
        .tgt     (tgt[i]),
        .step    (ctrl_step),
        .nxt     (cur_nxt[i]),
        .changed (ch_chg[i])
      );
    end
  endgenerate

  always_comb begin
    for (int g = 0; g < 3; g++) begin
      cur_grp[g] = {cur[4*g+3], cur[4*g+2], cur[4*g+1], cur[4*g]};
      tgt_grp[g] = {tgt[4*g+3], tgt[4*g+2], tgt[4*g+1], tgt[4*g]};
      grp_chg[g] = |ch_chg[4*g +: 4];
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      2'd0:    rdata = {busy, err, 18'd0, ctrl_step, ctrl_prsc, ctrl_en};
      2'd1:    rdata = tgt_grp[0];
      2'd2:    rdata = tgt_grp[1];
      default: rdata = tgt_grp[2];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (pending || tick) state_nxt = STEP;
             else if (dirty != 3'd0) state_nxt = ISSUE;
      STEP:  state_nxt = ((dirty | grp_chg) != 3'd0) ? ISSUE : IDLE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (pwm_ack_i || timeout) state_nxt = (dirty != 3'd0) ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (disable_wr) state_nxt = IDLE;
  end

  // Address/data are live during ISSUE and then held from the registered copy.
  always_comb begin
    pwm_wren_o = 1'b0;
    pwm_addr_o = addr_q;
    pwm_data_o = wdata_q;
    if (state == ISSUE) begin
      pwm_wren_o = 1'b1;
      pwm_addr_o = pwm_dc_addr(issue_g);
      pwm_data_o = (issue_g == 2'd2) ? cur_grp[2] :
                   (issue_g == 2'd1) ? cur_grp[1] : cur_grp[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_en   <= 1'b0;
      ctrl_prsc <= '0;
      ctrl_step <= '0;
      err       <= 1'b0;
      dirty     <= '0;
      pending   <= 1'b0;
      tmo       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ack_o     <= 1'b0;
      data_o    <= '0;
      for (int c = 0; c < NCH; c++) begin
        cur[c] <= '0;
        tgt[c] <= '0;
      end
    end else begin
      ack_o   <= acc_rd | acc_wr;
      data_o  <= acc_rd ? rdata : '0;
      addr_q  <= pwm_addr_o;
      wdata_q <= pwm_data_o;

      if (ctrl_wr) begin
        ctrl_en   <= data_i[0];
        ctrl_prsc <= data_i[3:1];
        ctrl_step <= data_i[11:4];
        err       <= 1'b0;
      end else if (timeout) begin
        err <= 1'b1;
      end

      for (int g = 0; g < 3; g++) begin
        if (acc_wr && (sel == 2'(g + 1))) begin
          for (int b = 0; b < 4; b++) begin
            tgt[4*g+b] <= (4*g + b < NUM_CHANNELS) ? data_i[8*b +: 8] : 8'd0;
          end
        end
      end

      for (int c = 0; c < NCH; c++) begin
        if (snap) cur[c] <= tgt[c];
        else if (state == STEP) cur[c] <= cur_nxt[c];
      end

      if (disable_wr)          dirty <= '0;
      else if (snap)           dirty <= 3'b111;
      else if (state == STEP)  dirty <= dirty | grp_chg;
      else if (state == ISSUE) dirty <= dirty & ~(3'b001 << issue_g);

      // A tick that arrives while the engine is busy is remembered once; a consumed
      // pending tick coinciding with a fresh one keeps the fresh one.
      if (disable_wr)         pending <= 1'b0;
      else if (state == IDLE) pending <= pending & tick;
      else if (tick)          pending <= 1'b1;

      if (state == ISSUE)     tmo <= '0;
      else if (state == WAIT) tmo <= tmo + 8'd1;
    end
  end

endmodule

// File: tb/tb_cellrv32_pwm_fader.sv
// Scoreboard bench for the PWM fade engine: a per-channel reference model predicts every master write.
module tb_cellrv32_pwm_fader;
  import cellrv32_package::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] addr_i;
  logic        rden_i;
  logic        wren_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        clkgen_en_o;
  logic [7:0]  clkgen_i;
  logic [31:0] pwm_addr_o;
  logic        pwm_wren_o;
  logic [31:0] pwm_data_o;
  logic        pwm_ack_i;

  cellrv32_pwm_fader #(.NUM_CHANNELS(12), .ACK_TIMEOUT(15)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .addr_i      (addr_i),
    .rden_i      (rden_i),
    .wren_i      (wren_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .ack_o       (ack_o),
    .clkgen_en_o (clkgen_en_o),
    .clkgen_i    (clkgen_i),
    .pwm_addr_o  (pwm_addr_o),
    .pwm_wren_o  (pwm_wren_o),
    .pwm_data_o  (pwm_data_o),
    .pwm_ack_i   (pwm_ack_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          m_cur [12];
  int          m_tgt [12];
  int          m_step, m_prsc;
  bit          m_en, m_err;
  logic [63:0] exp_q [$];
  int          wcyc_q [$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          ack_dly = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] pack_cur(input int g);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'(m_cur[4*g+b]);
    return w;
  endfunction

  function automatic logic [31:0] pack_tgt(input int g);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'(m_tgt[4*g+b]);
    return w;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 12; c++) begin
      m_cur[c] = 0;
      m_tgt[c] = 0;
    end
    m_step = 0; m_prsc = 0; m_en = 0; m_err = 0;
  endfunction

  function automatic void push_group(input int g);
    exp_q.push_back({pwm_dc_addr(2'(g)), pack_cur(g)});
    if (ack_dly == 0) m_err = 1;
  endfunction

  // Move every channel toward its target by at most m_step; report changed groups in order.
  function automatic void model_step();
    bit [2:0] chg = '0;
    if (!m_en) return;
    for (int c = 0; c < 12; c++) begin
      int v = m_cur[c];
      if (m_tgt[c] > v)      v = (m_tgt[c] - v <= m_step) ? m_tgt[c] : v + m_step;
      else if (m_tgt[c] < v) v = (v - m_tgt[c] <= m_step) ? m_tgt[c] : v - m_step;
      if (v != m_cur[c]) chg[c/4] = 1'b1;
      m_cur[c] = v;
    end
    for (int g = 0; g < 3; g++) if (chg[g]) push_group(g);
  endfunction

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr_i = a; data_i = d; wren_i = 1'b1;
    @(negedge clk);
    wren_i = 1'b0;
    check("wr_ack", ack_o, 1);
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr_i = a; rden_i = 1'b1;
    @(negedge clk);
    rden_i = 1'b0;
    check("rd_ack", ack_o, 1);
    d = data_o;
  endtask

  task automatic wr_tgt(input int g, input logic [31:0] d);
    logic [31:0] rb;
    for (int b = 0; b < 4; b++) m_tgt[4*g+b] = int'(d[8*b +: 8]);
    bus_wr(pwm_fader_tgt0_addr_c + 32'(4*g), d);
    bus_rd(pwm_fader_tgt0_addr_c + 32'(4*g), rb);
    check("tgt_readback", rb, pack_tgt(g));
  endtask

  task automatic wr_ctrl(input bit en, input int prsc, input int step, input bit snap);
    m_en = en; m_prsc = prsc; m_step = step; m_err = 0;
    if (snap && en) begin
      for (int c = 0; c < 12; c++) m_cur[c] = m_tgt[c];
      for (int g = 0; g < 3; g++) push_group(g);
    end
    bus_wr(pwm_fader_ctrl_addr_c, {19'd0, snap, 8'(step), 3'(prsc), en});
    if (!en) exp_q.delete();
  endtask

  task automatic check_ctrl(input string name);
    logic [31:0] rb;
    bus_rd(pwm_fader_ctrl_addr_c, rb);
    check(name, rb, {1'b0, m_err, 18'd0, 8'(m_step), 3'(m_prsc), m_en});
  endtask

  task automatic tick();
    logic [7:0] mask = 8'(1 << m_prsc);
    @(negedge clk);
    clkgen_i = (8'($urandom) & ~mask) | mask;
    model_step();
    @(negedge clk);
    clkgen_i = 8'($urandom) & ~mask;
    @(negedge clk);
    clkgen_i = '0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check({name, "_drain"}, 64'(exp_q.size()), 0);
    exp_q.delete();
    check_ctrl({name, "_ctrl"});
  endtask

  task automatic wait_wren();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pwm_wren_o) break;
    end
    check("wren_seen", 64'(i < 200), 1);
  endtask

  // Monitor: every master write must match the head of the expected queue.
  initial begin
    logic        prev = 1'b0;
    logic [63:0] last = '0;
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (prev) begin
        check("wren_width", pwm_wren_o, 0);
        check("pwm_hold", {pwm_addr_o, pwm_data_o}, last);
      end
      if (pwm_wren_o) begin
        wcyc_q.push_back(cyc);
        last = {pwm_addr_o, pwm_data_o};
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: addr %h data %h, no write expected", pwm_addr_o, pwm_data_o);
        end else begin
          e = exp_q.pop_front();
          check("pwm_write", {pwm_addr_o, pwm_data_o}, e);
        end
      end
      prev = pwm_wren_o;
    end
  end

  // PWM slave stand-in: acks ack_dly cycles after each write strobe; ack_dly==0 never acks.
  initial begin
    int ack_cnt = 0;
    pwm_ack_i = 1'b0;
    forever begin
      @(negedge clk);
      pwm_ack_i = 1'b0;
      if (ack_cnt != 0) begin
        ack_cnt--;
        if (ack_cnt == 0) pwm_ack_i = 1'b1;
      end
      if (pwm_wren_o && ack_dly != 0) ack_cnt = ack_dly;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] rb;
    rst_i = 1'b1; addr_i = '0; rden_i = 1'b0; wren_i = 1'b0; data_i = '0; clkgen_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_bus", {data_o, 31'd0, ack_o}, 0);
    check("rst_master", {pwm_addr_o, pwm_data_o}, 0);
    check("rst_ctl", {pwm_wren_o, clkgen_en_o}, 0);
    rst_i = 1'b0;
    check_ctrl("rst_ctrl_reg");

    // Ramp 0x00 -> 0x10 in steps of 4
    ack_dly = 1;
    wr_tgt(0, 32'h0000_0010);
    wr_ctrl(1, 0, 4, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      wait_idle("ramp");
    end

    // Clamp at 0xFF with a large step
    wr_tgt(0, 32'h0000_00FA);
    wr_ctrl(1, 0, 16, 1);
    wait_idle("snap");
    wr_tgt(0, 32'h0000_00FF);
    tick();
    wait_idle("clamp1");
    tick();
    wait_idle("clamp2");

    // Groups 0 and 2 only
    ack_dly = 2;
    wr_ctrl(1, 3, 8, 0);
    wr_tgt(0, 32'h2040_6080);
    wr_tgt(2, 32'h0102_0304);
    tick();
    wait_idle("multi");

    // No ack: each write times out, err sets, both groups still go out
    ack_dly = 0;
    wr_tgt(0, 32'h0000_0000);
    wr_tgt(1, 32'h5555_5555);
    wcyc_q.delete();
    tick();
    wait_idle("timeout");
    if (wcyc_q.size() >= 2) check("timeout_gap", 64'(wcyc_q[1] - wcyc_q[0]), 16);
    else check("timeout_writes", 64'(wcyc_q.size()), 2);
    ack_dly = 2;
    wr_ctrl(1, 3, 8, 0);
    check_ctrl("err_clear");

    // Three ticks during WAIT collapse to one extra step
    ack_dly = 8;
    wr_ctrl(1, 1, 2, 0);
    wr_tgt(0, 32'h8080_8080);
    wr_tgt(1, 32'hA0A0_A0A0);
    tick();
    wait_wren();
    model_step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      clkgen_i = 8'(1 << m_prsc);
    end
    @(negedge clk);
    clkgen_i = '0;
    wait_idle("busy_tick");

    // Disable mid-WAIT
    ack_dly = 10;
    wr_ctrl(1, 0, 4, 0);
    wr_tgt(0, 32'h1111_1111);
    wr_tgt(1, 32'h2222_2222);
    tick();
    wait_wren();
    wr_ctrl(0, 0, 4, 0);
    check("dis_clkgen", clkgen_en_o, 0);
    check_ctrl("dis_ctrl");
    repeat (30) @(negedge clk);
    tick();
    wait_idle("dis_after");

    // Reset mid-WAIT
    wr_ctrl(1, 0, 4, 0);
    wr_tgt(2, 32'h3333_3333);
    tick();
    wait_wren();
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("mid_rst_master", {pwm_addr_o, pwm_data_o}, 0);
    check("mid_rst_ctl", {pwm_wren_o, clkgen_en_o}, 0);
    exp_q.delete();
    model_reset();
    repeat (30) @(negedge clk);
    wait_idle("mid_rst");
    bus_rd(pwm_fader_tgt2_addr_c, rb);
    check("mid_rst_tgt2", rb, 0);

    // Randomized traffic
    wr_ctrl(1, 0, 5, 0);
    for (int it = 0; it < 60; it++) begin
      int op = $urandom_range(0, 9);
      ack_dly = $urandom_range(1, 4);
      if (op <= 3) begin
        wr_tgt($urandom_range(0, 2), $urandom);
      end else if (op == 4) begin
        int st = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 8) : $urandom_range(0, 255);
        wr_ctrl($urandom_range(0, 5) != 0, $urandom_range(0, 7), st, $urandom_range(0, 3) == 0);
        wait_idle("rnd_ctrl");
      end else begin
        tick();
        wait_idle("rnd_tick");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
